updown_counter_p: RTL

UPDOWN_COUNTER_P -- requirements
Module: updown_counter_p

---
 rtl/updown_counter_p.sv | 96 +++++++++
 1 files changed

// File: rtl/updown_counter_p.sv
// updown_counter_p: bounded up/down counter with a runtime [lo,hi] window.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   reset     - asynchronous, active-high reset
//   en        - count enable (step this cycle)
//   mode      - direction: 1 = up, 0 = down
//   sat       - boundary policy: 1 = saturate, 0 = wrap
//   load      - synchronous load strobe (wins over en)
//   load_val  - value to load, clamped into [lo,hi]
//   lo, hi    - runtime unsigned bounds
//   Ankit_out - registered count value
//   tc        - registered terminal-count pulse (boundary step taken last edge)
//   cfg_err   - registered bound error flag (lo > hi)
//   wrap_cnt  - registered count of wrap events, modulo 2^WRAP_CNT_W
module updown_counter_p #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sat,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      lo,
    input  logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      Ankit_out,
    output logic                  tc,
    output logic                  cfg_err,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    logic [WIDTH-1:0]      count_q, count_d;
    logic                  tc_q, tc_d;
    logic                  err_q, err_d;
    logic [WRAP_CNT_W-1:0] wrap_q, wrap_d;
    logic                  at_bound;

    // Boundary in the direction of travel; only meaningful when count is in range.
    assign at_bound = mode ? (count_q == hi) : (count_q == lo);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        wrap_d  = wrap_q;
        err_d   = (lo > hi);
        if (!err_d) begin
            if (load) begin
                if (load_val < lo) begin
                    count_d = lo;
                end else if (load_val > hi) begin
                    count_d = hi;
                end else begin
                    count_d = load_val;
                end
            end else if (en) begin
                if ((count_q < lo) || (count_q > hi)) begin
                    // Out of window (e.g. after reset or a bound change): resync.
                    count_d = mode ? lo : hi;
                end else if (at_bound) begin
                    tc_d = 1'b1;
                    if (!sat) begin
                        count_d = mode ? lo : hi;
                        wrap_d  = wrap_q + 1'b1;
                    end
                end else if (mode) begin
                    count_d = count_q + 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Ankit_out = count_q;
    assign tc        = tc_q;
    assign cfg_err   = err_q;
    assign wrap_cnt  = wrap_q;

endmodule
